// File: rtl/morph_pkg.sv
// morph_pkg: shared defaults and row-fill state encoding for the morphology pipeline
package morph_pkg;

    localparam int MORPH_WIDTH     = 24;
    localparam int MORPH_PIC_WIDTH = 250;

    typedef enum logic [1:0] {
        FILL0  = 2'd0,
        FILL1  = 2'd1,
        STREAM = 2'd2
    } row_state_t;

endpackage

// File: rtl/line_buf_ram.sv
// line_buf_ram: simple dual-port synchronous line RAM, 1-cycle read, read-before-write
module line_buf_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 250,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // write and registered read share one edge, so a same-address read returns the old word
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/matrix_rows_gen.sv
// matrix_rows_gen: buffers two image rows and emits aligned (y-2, y-1, y) column triples
module matrix_rows_gen
    import morph_pkg::*;
#(
    parameter int WIDTH     = MORPH_WIDTH,
    parameter int PIC_WIDTH = MORPH_PIC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sof,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] din,
    output logic             valid_out,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3
);
    localparam int            CW   = $clog2(PIC_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(PIC_WIDTH - 1);

    row_state_t       state, state_nx, cur;
    logic [CW-1:0]    col, col_nx, addr, wr_addr;
    logic             take, wr_a;
    logic [WIDTH-1:0] a_q, b_q, d3, h1, h2;

    // a qualified sof restarts the pixel as column 0 of FILL0; column LAST advances the fill
    always_comb begin
        cur      = (valid_in && sof) ? FILL0 : state;
        addr     = (valid_in && sof) ? '0 : col;
        col_nx   = col;
        state_nx = state;
        take     = 1'b0;
        if (valid_in) begin
            col_nx   = (addr == LAST) ? '0 : addr + CW'(1);
            take     = (cur == STREAM);
            state_nx = cur;
            if (addr == LAST && cur != STREAM)
                state_nx = (cur == FILL0) ? FILL1 : STREAM;
        end
    end

    // fill state, column counter, output qualifier and the deferred row y-2 write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL0;
            col       <= '0;
            valid_out <= 1'b0;
            d3        <= '0;
            wr_a      <= 1'b0;
            wr_addr   <= '0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            valid_out <= take;
            wr_a      <= valid_in;
            wr_addr   <= addr;
            if (take)
                d3 <= din;
        end
    end

    // remember the last emitted upper rows so the outputs hold while valid_out is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1 <= '0;
            h2 <= '0;
        end else if (valid_out) begin
            h1 <= a_q;
            h2 <= b_q;
        end
    end

    // row y-2: takes the old row y-1 word one cycle after it was read out of lb_b
    line_buf_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(CW)) u_lb_a (
        .clk   (clk),
        .we    (wr_a),
        .waddr (wr_addr),
        .wdata (b_q),
        .re    (valid_in),
        .raddr (addr),
        .rdata (a_q)
    );

    // row y-1: overwritten by the incoming pixel after its old word is read
    line_buf_ram #(.WIDTH(WIDTH), .DEPTH(PIC_WIDTH), .AW(CW)) u_lb_b (
        .clk   (clk),
        .we    (valid_in),
        .waddr (addr),
        .wdata (din),
        .re    (valid_in),
        .raddr (addr),
        .rdata (b_q)
    );

    assign dout1 = valid_out ? a_q : h1;
    assign dout2 = valid_out ? b_q : h2;
    assign dout3 = d3;

endmodule

// File: tb/tb_matrix_rows_gen.sv
// tb_matrix_rows_gen: table, directed and random checks of the three-row window generator
module tb_matrix_rows_gen;
    localparam int PW = 4;
    localparam int W  = 24;

    typedef struct {
        logic         v;
        logic         s;
        logic [W-1:0] d;
        logic         ev;
        logic [W-1:0] e1, e2, e3;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sof, valid_in, valid_out;
    logic [W-1:0] din, dout1, dout2, dout3;
    logic         sof_d, vi_d, vo_d;
    logic [W-1:0] din_d, do1_d, do2_d, do3_d;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] hist [$];
    logic         ev;
    logic [W-1:0] e1, e2, e3;

    always #5 clk = ~clk;

    matrix_rows_gen #(.WIDTH(W), .PIC_WIDTH(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof),
        .valid_in  (valid_in),
        .din       (din),
        .valid_out (valid_out),
        .dout1     (dout1),
        .dout2     (dout2),
        .dout3     (dout3)
    );

    matrix_rows_gen dut_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof_d),
        .valid_in  (vi_d),
        .din       (din_d),
        .valid_out (vo_d),
        .dout1     (do1_d),
        .dout2     (do2_d),
        .dout3     (do3_d)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a window exists once 2*PW pixels of the current frame have been seen
    task automatic model_reset();
        hist.delete();
        ev = 1'b0;
        e1 = '0;
        e2 = '0;
        e3 = '0;
    endtask

    task automatic model_step(input logic v, input logic s, input logic [W-1:0] d);
        ev = 1'b0;
        if (v) begin
            if (s)
                hist.delete();
            if (hist.size() == 2 * PW) begin
                ev = 1'b1;
                e1 = hist[0];
                e2 = hist[PW];
                e3 = d;
            end
            hist.push_back(d);
            if (hist.size() > 2 * PW)
                void'(hist.pop_front());
        end
    endtask

    task automatic check_out(input string tag);
        cmp({tag, "_vo"}, 32'(valid_out), 32'(ev));
        cmp({tag, "_d1"}, 32'(dout1), 32'(e1));
        cmp({tag, "_d2"}, 32'(dout2), 32'(e2));
        cmp({tag, "_d3"}, 32'(dout3), 32'(e3));
    endtask

    task automatic step(input string tag, input logic v, input logic s, input logic [W-1:0] d);
        valid_in = v;
        sof      = s;
        din      = d;
        @(posedge clk);
        #1;
        model_step(v, s, d);
        check_out(tag);
    endtask

    task automatic pulse_reset(input string tag);
        valid_in = 1'b0;
        sof      = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        check_out({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        check_out({tag, "_held"});
        cmp({tag, "_col"}, 32'(dut.col), 32'd0);
        cmp({tag, "_st"}, 32'(dut.state), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vt [12];
        int   nvalid;
        rst_n    = 1'b0;
        sof      = 1'b0;
        valid_in = 1'b0;
        din      = '0;
        sof_d    = 1'b0;
        vi_d     = 1'b0;
        din_d    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out("reset");
        cmp("reset_col", 32'(dut.col), 32'd0);
        cmp("reset_st", 32'(dut.state), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            vt[i] = '{1'b1, 1'(i == 0), W'(i + 1), 1'b0, '0, '0, '0};
        vt[8]  = '{1'b1, 1'b0, 24'd9,  1'b1, 24'd1, 24'd5, 24'd9};
        vt[9]  = '{1'b1, 1'b0, 24'd10, 1'b1, 24'd2, 24'd6, 24'd10};
        vt[10] = '{1'b1, 1'b0, 24'd11, 1'b1, 24'd3, 24'd7, 24'd11};
        vt[11] = '{1'b1, 1'b0, 24'd12, 1'b1, 24'd4, 24'd8, 24'd12};
        for (int i = 0; i < 12; i++) begin
            step("tbl_model", vt[i].v, vt[i].s, vt[i].d);
            cmp("tbl_vo", 32'(valid_out), 32'(vt[i].ev));
            cmp("tbl_d1", 32'(dout1), 32'(vt[i].e1));
            cmp("tbl_d2", 32'(dout2), 32'(vt[i].e2));
            cmp("tbl_d3", 32'(dout3), 32'(vt[i].e3));
        end

        // same frame with a bubble after every pixel
        for (int i = 0; i < 12; i++) begin
            step("toggle", 1'b1, 1'(i == 0), W'(i + 1));
            step("toggle_gap", 1'b0, 1'b0, W'(24'hdead));
        end

        // five rows, then a fresh frame that must not leak old rows
        for (int i = 0; i < 5 * PW; i++)
            step("rows5", 1'b1, 1'(i == 0), W'(100 + i));
        for (int i = 0; i < 3 * PW; i++)
            step("newfrm", 1'b1, 1'(i == 0), W'(500 + i));

        // reset at row 3 column 2, then refill without sof
        for (int i = 0; i < 3 * PW + 2; i++)
            step("prerst", 1'b1, 1'(i == 0), W'(700 + i));
        pulse_reset("midrst");
        for (int i = 0; i < 3 * PW; i++)
            step("postrst", 1'b1, 1'b0, W'(800 + i));

        // sof landing on the last column of FILL1
        for (int i = 0; i < 2 * PW - 1; i++)
            step("sofwrap_pre", 1'b1, 1'(i == 0), W'(900 + i));
        step("sofwrap", 1'b1, 1'b1, W'(950));
        cmp("sofwrap_col", 32'(dut.col), 32'd1);
        cmp("sofwrap_st", 32'(dut.state), 32'd0);
        step("sofwrap_next", 1'b1, 1'b0, W'(951));

        // sof without valid_in changes nothing
        for (int i = 0; i < 2 * PW + 2; i++)
            step("sofnov", 1'b1, 1'b0, W'(1000 + i));
        step("sofnov_idle", 1'b0, 1'b1, W'(1100));
        for (int i = 0; i < PW; i++)
            step("sofnov_after", 1'b1, 1'b0, W'(1200 + i));

        // random traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(999) < 4)
                pulse_reset("rnd_rst");
            step("rnd", 1'($urandom_range(99) < 70), 1'($urandom_range(99) < 3), W'($urandom));
        end
        valid_in = 1'b0;
        sof      = 1'b0;

        // default geometry with a row/column ramp
        nvalid = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 250; c++) begin
                vi_d  = 1'b1;
                sof_d = 1'(r == 0 && c == 0);
                din_d = W'(c + 256 * r);
                @(posedge clk);
                #1;
                cmp("ramp_vo", 32'(vo_d), 32'(r >= 2));
                if (vo_d) begin
                    nvalid++;
                    cmp("ramp_d3", 32'(do3_d), 32'(c + 256 * r));
                    cmp("ramp_d32", 32'(W'(do3_d - do2_d)), 32'd256);
                    cmp("ramp_d21", 32'(W'(do2_d - do1_d)), 32'd256);
                end
            end
        end
        vi_d  = 1'b0;
        sof_d = 1'b0;
        cmp("ramp_count", 32'(nvalid), 32'd750);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
